// File: rtl/ahb_sram_wait_slave.sv
// AHB-Lite SRAM slave with configurable read/write wait states and a two-cycle ERROR response.
// Illegal size, misalignment or out-of-window addresses are rejected when the transfer is accepted.
module ahb_sram_wait_slave #(
  parameter int MEM_AW    = 10,
  parameter int REGION_AW = 20,
  parameter int WAIT_RD   = 1,
  parameter int WAIT_WR   = 0
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic [31:0] HWDATA,
  input  logic        HREADYMUX,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA,
  output logic [7:0]  err_cnt
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_ERR1 = 3'd3;
  localparam logic [2:0] S_ERR2 = 3'd4;
  localparam int DEPTH = 1 << MEM_AW;
  localparam logic [3:0] N_RD = 4'(WAIT_RD);
  localparam logic [3:0] N_WR = 4'(WAIT_WR);
  // Address bits above the memory but inside the decoded region must be zero.
  localparam logic [31:0] WIN_MASK = ((32'h1 << REGION_AW) - 32'h1) &
                                     ~((32'h1 << (MEM_AW + 2)) - 32'h1);

  logic [2:0]        state;
  logic [3:0]        wcnt;
  logic [MEM_AW-1:0] idx_q;
  logic [1:0]        lo_q;
  logic [1:0]        size_q;
  logic              wr_q;
  logic [3:0]        be;
  logic              accept, illegal;
  logic [3:0]        nwait;
  logic [3:0][7:0]   mem [DEPTH];

  logic unused_ok;
  assign unused_ok = ^{HBURST, HPROT, HTRANS[0]};

  assign HREADYOUT = (state != S_WAIT) && (state != S_ERR1);
  assign HRESP     = (state == S_ERR1) || (state == S_ERR2);
  assign HRDATA    = (state == S_DATA && !wr_q) ? mem[idx_q] : 32'h0;

  assign accept  = HSEL && HREADYMUX && HTRANS[1] && HREADYOUT;
  assign illegal = (HSIZE > 3'd2) ||
                   (HSIZE == 3'd1 && HADDR[0]) ||
                   (HSIZE == 3'd2 && (HADDR[1:0] != 2'b00)) ||
                   ((HADDR & WIN_MASK) != 32'h0);
  assign nwait   = HWRITE ? N_WR : N_RD;

  always_comb begin
    be = 4'b1111;
    if (size_q == 2'd0)      be = 4'b0001 << lo_q;
    else if (size_q == 2'd1) be = lo_q[1] ? 4'b1100 : 4'b0011;
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state   <= S_IDLE;
      wcnt    <= 4'd0;
      err_cnt <= 8'd0;
      idx_q   <= '0;
      lo_q    <= 2'd0;
      size_q  <= 2'd0;
      wr_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DATA, S_ERR2: begin
          if (accept) begin
            idx_q  <= HADDR[MEM_AW+1:2];
            lo_q   <= HADDR[1:0];
            size_q <= HSIZE[1:0];
            wr_q   <= HWRITE && !illegal;
            if (illegal) state <= S_ERR1;
            else if (nwait != 4'd0) begin
              state <= S_WAIT;
              wcnt  <= nwait - 4'd1;
            end else state <= S_DATA;
          end else begin
            state <= S_IDLE;
            wr_q  <= 1'b0;
          end
        end
        S_WAIT: begin
          if (wcnt == 4'd0) state <= S_DATA;
          else wcnt <= wcnt - 4'd1;
        end
        S_ERR1: begin
          state <= S_ERR2;
          if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Commit on the edge that closes the write data phase; a reset on that edge drops it.
  always_ff @(posedge hclk) begin
    if (!hreset && state == S_DATA && wr_q) begin
      for (int l = 0; l < 4; l++)
        if (be[l]) mem[idx_q][l] <= HWDATA[8*l +: 8];
    end
  end
endmodule

// File: tb/tb_ahb_sram_wait_slave.sv
// Directed table-driven bench for ahb_sram_wait_slave (default parameters: WAIT_RD=1, WAIT_WR=0).
// Each table row is one bus cycle: outputs checked at the falling edge, then that cycle's inputs driven.
module tb_ahb_sram_wait_slave;
  logic        hclk, hreset, HSEL, HWRITE, HREADYMUX;
  logic [31:0] HADDR, HWDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic        HREADYOUT, HRESP;
  logic [31:0] HRDATA;
  logic [7:0]  err_cnt;

  int nchk = 0;
  int nerr = 0;

  localparam logic [1:0] ID = 2'b00, BZ = 2'b01, NS = 2'b10, SQ = 2'b11;

  typedef struct {
    logic        sel;
    logic [31:0] addr;
    logic        wr;
    logic [1:0]  trans;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic        rmux;
    logic        e_rdy;
    logic        e_resp;
    logic [31:0] e_rdata;
    logic [7:0]  e_err;
  } vec_t;

  vec_t vecs[$];

  ahb_sram_wait_slave dut (
    .hclk(hclk), .hreset(hreset), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
    .HTRANS(HTRANS), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
    .HREADYMUX(HREADYMUX), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
    .err_cnt(err_cnt)
  );

  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic rdy, input logic resp,
                         input logic [31:0] rdata, input logic [7:0] err);
    chk({tag, " hreadyout"}, {31'b0, HREADYOUT}, {31'b0, rdy});
    chk({tag, " hresp"},     {31'b0, HRESP},     {31'b0, resp});
    chk({tag, " hrdata"},    HRDATA,             rdata);
    chk({tag, " err_cnt"},   {24'b0, err_cnt},   {24'b0, err});
  endtask

  task automatic drv(input logic sel, input logic [31:0] addr, input logic wr,
                     input logic [1:0] trans, input logic [2:0] size,
                     input logic [31:0] wdata, input logic rmux);
    HSEL = sel; HADDR = addr; HWRITE = wr; HTRANS = trans;
    HSIZE = size; HWDATA = wdata; HREADYMUX = rmux;
  endtask

  task automatic idle(input logic rmux, input logic [31:0] wdata = 32'h0);
    drv(1'b0, 32'h0, 1'b0, ID, 3'd0, wdata, rmux);
  endtask

  task automatic add(input logic sel, input logic [31:0] addr, input logic wr,
                     input logic [1:0] trans, input logic [2:0] size, input logic [31:0] wdata,
                     input logic rmux, input logic rdy, input logic resp,
                     input logic [31:0] rdata, input logic [7:0] err);
    vec_t v;
    v.sel = sel; v.addr = addr; v.wr = wr; v.trans = trans; v.size = size;
    v.wdata = wdata; v.rmux = rmux; v.e_rdy = rdy; v.e_resp = resp;
    v.e_rdata = rdata; v.e_err = err;
    vecs.push_back(v);
  endtask

  initial begin
    HBURST = 3'd0;
    HPROT  = 4'd0;
    hreset = 1'b1;
    idle(1'b1);

    // sel addr wr trans size wdata rmux | rdy resp rdata err
    // word write then read with one read wait state
    add(1, 32'h10, 1, NS, 2, 32'h0,        1, 1, 0, 32'h0,        0);
    add(1, 32'h10, 0, NS, 2, 32'hDEADBEEF, 1, 1, 0, 32'h0,        0);
    add(0, 32'h0,  0, ID, 0, 32'h0,        0, 0, 0, 32'h0,        0);
    add(0, 32'h0,  0, ID, 0, 32'h0,        1, 1, 0, 32'hDEADBEEF, 0);
    add(0, 32'h0,  0, ID, 0, 32'h0,        1, 1, 0, 32'h0,        0);
    // byte and halfword lane merging
    add(1, 32'h10, 1, NS, 2, 32'h0,        1, 1, 0, 32'h0,        0);
    add(1, 32'h13, 1, NS, 0, 32'h11223344, 1, 1, 0, 32'h0,        0);
    add(1, 32'h10, 0, NS, 2, 32'hAAFFFFFF, 1, 1, 0, 32'h0,        0);
    add(0, 32'h0,  0, ID, 0, 32'h0,        0, 0, 0, 32'h0,        0);
    add(1, 32'h12, 1, NS, 1, 32'h0,        1, 1, 0, 32'hAA223344, 0);
    add(1, 32'h10, 0, NS, 2, 32'h5566FFFF, 1, 1, 0, 32'h0,        0);
    add(0, 32'h0,  0, ID, 0, 32'h0,        0, 0, 0, 32'h0,        0);
    add(0, 32'h0,  0, ID, 0, 32'h0,        1, 1, 0, 32'h55663344, 0);
    // misaligned word read -> ERROR pair
    add(1, 32'h2,  0, NS, 2, 32'h0,        1, 1, 0, 32'h0,        0);
    add(0, 32'h0,  0, ID, 0, 32'h0,        0, 0, 1, 32'h0,        0);
    add(0, 32'h0,  0, ID, 0, 32'h0,        1, 1, 1, 32'h0,        1);
    // out-of-window and HSIZE=3 writes must not touch memory
    add(1, 32'h0,    1, NS, 2, 32'h0,        1, 1, 0, 32'h0, 1);
    add(1, 32'h1000, 1, NS, 2, 32'h0BADF00D, 1, 1, 0, 32'h0, 1);
    add(0, 32'h0,    0, ID, 0, 32'hFFFFFFFF, 0, 0, 1, 32'h0, 1);
    add(1, 32'h10,   1, NS, 3, 32'h0,        1, 1, 1, 32'h0, 2);
    add(0, 32'h0,    0, ID, 0, 32'hFFFFFFFF, 0, 0, 1, 32'h0, 2);
    add(1, 32'h0,    0, NS, 2, 32'h0,        1, 1, 1, 32'h0, 3);
    add(0, 32'h0,    0, ID, 0, 32'h0,        0, 0, 0, 32'h0, 3);
    add(1, 32'h10,   0, SQ, 2, 32'h0,        1, 1, 0, 32'h0BADF00D, 3);
    add(0, 32'h0,    0, ID, 0, 32'h0,        0, 0, 0, 32'h0, 3);
    add(0, 32'h0,    0, ID, 0, 32'h0,        1, 1, 0, 32'h55663344, 3);
    // no-transfer cases: HREADYMUX low, IDLE, BUSY, HSEL low
    add(1, 32'h10, 0, NS, 2, 32'h0, 0, 1, 0, 32'h0, 3);
    add(1, 32'h10, 0, ID, 2, 32'h0, 1, 1, 0, 32'h0, 3);
    add(1, 32'h10, 0, BZ, 2, 32'h0, 1, 1, 0, 32'h0, 3);
    add(0, 32'h10, 0, NS, 2, 32'h0, 1, 1, 0, 32'h0, 3);
    add(0, 32'h0,  0, ID, 0, 32'h0, 1, 1, 0, 32'h0, 3);

    repeat (2) @(negedge hclk);
    chk_out("reset", 1'b1, 1'b0, 32'h0, 8'd0);
    hreset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge hclk);
      chk_out($sformatf("vec%0d", i), vecs[i].e_rdy, vecs[i].e_resp, vecs[i].e_rdata, vecs[i].e_err);
      drv(vecs[i].sel, vecs[i].addr, vecs[i].wr, vecs[i].trans, vecs[i].size,
          vecs[i].wdata, vecs[i].rmux);
    end

    // reset while a read is in its wait state
    @(negedge hclk);
    drv(1, 32'h10, 0, NS, 2, 32'h0, 1);
    @(negedge hclk);
    chk_out("rst_wait pre", 1'b0, 1'b0, 32'h0, 8'd3);
    hreset = 1'b1; idle(1'b0);
    @(negedge hclk);
    chk_out("rst_wait post", 1'b1, 1'b0, 32'h0, 8'd0);
    hreset = 1'b0; idle(1'b1);

    // reset on the edge closing a write data phase drops the write
    @(negedge hclk);
    drv(1, 32'h10, 1, NS, 2, 32'h0, 1);
    @(negedge hclk);
    hreset = 1'b1; idle(1'b1, 32'h12345678);
    @(negedge hclk);
    hreset = 1'b0;
    drv(1, 32'h10, 0, NS, 2, 32'h0, 1);
    @(negedge hclk);
    idle(1'b0);
    @(negedge hclk);
    chk("rst_write dropped", HRDATA, 32'h55663344);
    idle(1'b1);

    // reset during ERR1
    @(negedge hclk);
    drv(1, 32'h3, 1, NS, 2, 32'h0, 1);
    @(negedge hclk);
    chk_out("rst_err1 pre", 1'b0, 1'b1, 32'h0, 8'd0);
    hreset = 1'b1; idle(1'b0);
    @(negedge hclk);
    chk_out("rst_err1 post", 1'b1, 1'b0, 32'h0, 8'd0);
    hreset = 1'b0; idle(1'b1);

    // 260 back-to-back errors saturate err_cnt at 255
    for (int k = 0; k < 260; k++) begin
      @(negedge hclk);
      drv(1, 32'h2, 0, NS, 2, 32'h0, 1);
      @(negedge hclk);
      idle(1'b0);
    end
    @(negedge hclk);
    chk_out("sat err2", 1'b1, 1'b1, 32'h0, 8'd255);
    idle(1'b1);
    @(negedge hclk);
    chk_out("sat idle", 1'b1, 1'b0, 32'h0, 8'd255);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
